// File: rtl/proj_pkg.sv
// Shared definitions for the k-mer extension block: padding base code and FSM state type.
package proj_pkg;

    localparam logic [3:0] BASE_N = 4'b0000;

    typedef enum logic [1:0] {
        StEmpty,
        StLoad,
        StServe,
        StDrain
    } state_e;

endpackage

// File: rtl/frag_window.sv
// One lane's fragment window: gathers FRAG_LEN bases centred on a k-mer start index,
// substituting the N code (and flagging pad) for positions outside the loaded sequence.
module frag_window
    import proj_pkg::*;
#(
    parameter int KMER_LEN   = 4,
    parameter int FRAG_LEN   = 8,
    parameter int BASE_LEN   = 4,
    parameter int ACTUAL_MEM = 32,
    localparam int INDICE_LEN = $clog2(ACTUAL_MEM),
    localparam int LEN_W      = INDICE_LEN + 1
) (
    input  logic [ACTUAL_MEM-1:0][BASE_LEN-1:0] mem_i,
    input  logic [LEN_W-1:0]                    seq_len_i,
    input  logic [INDICE_LEN-1:0]               idx_i,
    output logic [FRAG_LEN*BASE_LEN-1:0]        frag_o,
    output logic                                pad_o
);

    localparam int HALF_FLANK = (FRAG_LEN - KMER_LEN) / 2;
    localparam logic [LEN_W:0] FLANK_W = (LEN_W + 1)'(HALF_FLANK);

    logic [LEN_W:0] pos;
    logic           in_range;

    // pos is a two's-complement position; its MSB set means it fell before address 0.
    always_comb begin
        frag_o   = '0;
        pad_o    = 1'b0;
        pos      = '0;
        in_range = 1'b0;
        for (int j = 0; j < FRAG_LEN; j++) begin
            pos      = {2'b00, idx_i} - FLANK_W + (LEN_W + 1)'(j);
            in_range = !pos[LEN_W] && (pos[LEN_W-1:0] < seq_len_i);
            if (in_range) begin
                frag_o[j*BASE_LEN +: BASE_LEN] = mem_i[pos[INDICE_LEN-1:0]];
            end else begin
                frag_o[j*BASE_LEN +: BASE_LEN] = BASE_LEN'(BASE_N);
                pad_o                          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/kmer_extend_seq.sv
// Sequence buffer loaded by a base stream, then served as LANES-wide k-mer fragment lookups
// through a single registered response stage.
module kmer_extend_seq
    import proj_pkg::*;
#(
    parameter int KMER_LEN   = 4,
    parameter int FRAG_LEN   = 8,
    parameter int BASE_LEN   = 4,
    parameter int ACTUAL_MEM = 32,
    parameter int LANES      = 2,
    localparam int INDICE_LEN = $clog2(ACTUAL_MEM),
    localparam int LEN_W      = INDICE_LEN + 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      load_start,
    input  logic                                      load_valid,
    output logic                                      load_ready,
    input  logic [BASE_LEN-1:0]                       load_base,
    input  logic                                      load_last,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [LANES-1:0][INDICE_LEN-1:0]          req_indices,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [LANES-1:0][FRAG_LEN*BASE_LEN-1:0]   rsp_frags,
    output logic [LANES-1:0]                          rsp_pad,
    output logic [LEN_W-1:0]                          seq_len
);

    state_e                                  state_q, state_d;
    logic [LEN_W-1:0]                        seq_len_q, seq_len_d;
    logic                                    rsp_valid_q, rsp_valid_d;
    logic [LANES-1:0][FRAG_LEN*BASE_LEN-1:0] rsp_frags_q, rsp_frags_d;
    logic [LANES-1:0]                        rsp_pad_q, rsp_pad_d;

    logic [ACTUAL_MEM-1:0][BASE_LEN-1:0]     mem_q;
    logic                                    mem_we;
    logic [INDICE_LEN-1:0]                   mem_waddr;

    logic [LANES-1:0][FRAG_LEN*BASE_LEN-1:0] win_frags;
    logic [LANES-1:0]                        win_pad;
    logic                                    req_fire;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        frag_window #(
            .KMER_LEN   (KMER_LEN),
            .FRAG_LEN   (FRAG_LEN),
            .BASE_LEN   (BASE_LEN),
            .ACTUAL_MEM (ACTUAL_MEM)
        ) u_win (
            .mem_i     (mem_q),
            .seq_len_i (seq_len_q),
            .idx_i     (req_indices[l]),
            .frag_o    (win_frags[l]),
            .pad_o     (win_pad[l])
        );
    end

    always_comb begin
        state_d    = state_q;
        seq_len_d  = seq_len_q;
        load_ready = 1'b0;
        req_ready  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = seq_len_q[INDICE_LEN-1:0];

        unique case (state_q)
            StEmpty: begin
                if (load_start) begin
                    state_d   = StLoad;
                    seq_len_d = '0;
                end
            end
            StLoad: begin
                load_ready = seq_len_q < LEN_W'(ACTUAL_MEM);
                // A restart wins over any beat (including load_last) in the same cycle.
                if (load_start) begin
                    seq_len_d = '0;
                end else if (load_valid && load_ready) begin
                    mem_we    = 1'b1;
                    seq_len_d = seq_len_q + LEN_W'(1);
                    if (load_last || (seq_len_d == LEN_W'(ACTUAL_MEM))) begin
                        state_d = StServe;
                    end
                end
            end
            StServe: begin
                req_ready = !rsp_valid_q || rsp_ready;
                if (load_start) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!rsp_valid_q || rsp_ready) begin
                    state_d   = StLoad;
                    seq_len_d = '0;
                end
            end
            default: state_d = StEmpty;
        endcase

        // Handshakes are suppressed during reset so nothing is accepted or written.
        if (rst) begin
            load_ready = 1'b0;
            req_ready  = 1'b0;
            mem_we     = 1'b0;
        end
    end

    assign req_fire = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_frags_d = rsp_frags_q;
        rsp_pad_d   = rsp_pad_q;
        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_frags_d = win_frags;
            rsp_pad_d   = win_pad;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            seq_len_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_frags_q <= '0;
            rsp_pad_q   <= '0;
        end else begin
            state_q     <= state_d;
            seq_len_q   <= seq_len_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_frags_q <= rsp_frags_d;
            rsp_pad_q   <= rsp_pad_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= load_base;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_frags = rsp_frags_q;
    assign rsp_pad   = rsp_pad_q;
    assign seq_len   = seq_len_q;

endmodule

// File: tb/tb_kmer_extend_seq.sv
// Directed bench for kmer_extend_seq with default parameters and hand-computed fragments.
module tb_kmer_extend_seq;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_start;
    logic            load_valid;
    logic            load_ready;
    logic [3:0]      load_base;
    logic            load_last;
    logic            req_valid;
    logic            req_ready;
    logic [1:0][4:0] req_indices;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0][31:0] rsp_frags;
    logic [1:0]      rsp_pad;
    logic [5:0]      seq_len;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kmer_extend_seq dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_base   (load_base),
        .load_last   (load_last),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_indices (req_indices),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_frags   (rsp_frags),
        .rsp_pad     (rsp_pad),
        .seq_len     (seq_len)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_base = 4'h0;
        load_last = 1'b0;
        req_valid = 1'b0;
        req_indices = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_seq_len", 64'(seq_len), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_load_ready", 64'(load_ready), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_frags", 64'(rsp_frags), 64'd0);
        chk("rst_pad", 64'(rsp_pad), 64'd0);

        // Full 32-base load without load_last
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        settle();
        chk("load_entry_ready", 64'(load_ready), 64'd1);
        chk("load_entry_len", 64'(seq_len), 64'd0);
        load_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            load_base = 4'((i % 15) + 1);
            if (i == 31) begin
                settle();
                chk("ld_ready_beat31", 64'(load_ready), 64'd1);
            end
            tick();
        end
        load_valid = 1'b0;
        settle();
        chk("full_load_ready", 64'(load_ready), 64'd0);
        chk("full_seq_len", 64'(seq_len), 64'd32);
        chk("full_req_ready", 64'(req_ready), 64'd1);

        // Request {lane0=10, lane1=0}, held response
        req_indices[0] = 5'd10;
        req_indices[1] = 5'd0;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        settle();
        chk("req1_ready", 64'(req_ready), 64'd1);
        chk("req1_pre_valid", 64'(rsp_valid), 64'd0);
        tick();
        req_indices[0] = 5'd20;
        req_indices[1] = 5'd31;
        settle();
        chk("req1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("req1_lane0", 64'(rsp_frags[0]), 64'h1FEDCBA9);
        chk("req1_lane1", 64'(rsp_frags[1]), 64'h65432100);
        chk("req1_pad", 64'(rsp_pad), 64'b10);

        for (int c = 0; c < 5; c++) begin
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_lane0", 64'(rsp_frags[0]), 64'h1FEDCBA9);
            chk("stall_lane1", 64'(rsp_frags[1]), 64'h65432100);
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        chk("unstall_req_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        settle();
        chk("req2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("req2_lane0", 64'(rsp_frags[0]), 64'hBA987654);
        chk("req2_lane1", 64'(rsp_frags[1]), 64'h0000021F);
        chk("req2_pad", 64'(rsp_pad), 64'b10);
        tick();
        chk("req2_consumed", 64'(rsp_valid), 64'd0);

        // Pending response then load_start -> DRAIN
        rsp_ready = 1'b0;
        req_indices[0] = 5'd12;
        req_indices[1] = 5'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        settle();
        chk("drain_req_ready", 64'(req_ready), 64'd0);
        chk("drain_load_ready", 64'(load_ready), 64'd0);
        chk("drain_rsp_valid", 64'(rsp_valid), 64'd1);
        tick();
        chk("drain_hold_req_ready", 64'(req_ready), 64'd0);
        chk("drain_hold_load_ready", 64'(load_ready), 64'd0);
        rsp_ready = 1'b1;
        tick();
        chk("drain_exit_load_ready", 64'(load_ready), 64'd1);
        chk("drain_exit_seq_len", 64'(seq_len), 64'd0);
        chk("drain_exit_rsp_valid", 64'(rsp_valid), 64'd0);

        // Junk beats, then restart colliding with a load_last beat
        load_valid = 1'b1;
        load_base = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        chk("junk_seq_len", 64'(seq_len), 64'd3);
        load_start = 1'b1;
        load_last = 1'b1;
        load_base = 4'hE;
        tick();
        load_start = 1'b0;
        load_last = 1'b0;
        chk("restart_seq_len", 64'(seq_len), 64'd0);
        chk("restart_load_ready", 64'(load_ready), 64'd1);

        // 12-base load ending with load_last
        for (int i = 0; i < 12; i++) begin
            load_base = 4'(i + 1);
            load_last = (i == 11);
            tick();
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        settle();
        chk("short_seq_len", 64'(seq_len), 64'd12);
        chk("short_load_ready", 64'(load_ready), 64'd0);
        chk("short_req_ready", 64'(req_ready), 64'd1);

        req_indices[0] = 5'd10;
        req_indices[1] = 5'd20;
        req_valid = 1'b1;
        tick();
        req_indices[1] = 5'd2;
        chk("short1_valid", 64'(rsp_valid), 64'd1);
        chk("short1_lane0", 64'(rsp_frags[0]), 64'h0000CBA9);
        chk("short1_lane1", 64'(rsp_frags[1]), 64'h00000000);
        chk("short1_pad", 64'(rsp_pad), 64'b11);
        tick();
        req_valid = 1'b0;
        chk("short2_valid", 64'(rsp_valid), 64'd1);
        chk("short2_lane0", 64'(rsp_frags[0]), 64'h0000CBA9);
        chk("short2_lane1", 64'(rsp_frags[1]), 64'h87654321);
        chk("short2_pad", 64'(rsp_pad), 64'b01);
        tick();
        chk("short2_consumed", 64'(rsp_valid), 64'd0);

        // Reset in the middle of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tick();
        chk("reload_ready", 64'(load_ready), 64'd1);
        load_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            load_base = 4'(i + 2);
            tick();
        end
        chk("midload_seq_len", 64'(seq_len), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_valid = 1'b0;
        settle();
        chk("midrst_seq_len", 64'(seq_len), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_load_ready", 64'(load_ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
